btn_event_ctrl: RTL and testbench

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

---
 rtl/btn_event_pkg.sv | 18 +
 rtl/btn_event_chan.sv | 166 ++++++++++++++++
 rtl/btn_event_ctrl.sv | 46 ++++
 tb/tb_btn_event_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event controller: FSM state encoding
// and counter sizing.
package btn_event_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_ARM_PRESS   = 3'd1;
    localparam logic [2:0] ST_PRESSED     = 3'd2;
    localparam logic [2:0] ST_HELD        = 3'd3;
    localparam logic [2:0] ST_ARM_RELEASE = 3'd4;

    // Bits needed to hold max(a, b) without wrapping; never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_event_chan.sv
// One button channel: input synchroniser, debounce FSM, hold/repeat timing
// and registered event pulses.
module btn_event_chan
    import btn_event_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 2000000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    input  logic event_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic hold,
    output logic repeat_pulse,
    output logic toggle
);

    localparam int HW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES, 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [HW-1:0] HCNT_MAX  = {HW{1'b1}};
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    logic                   raw;
    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic [2:0]             state, state_nxt;
    logic [DW-1:0]          dbc, dbc_nxt;
    logic [HW-1:0]          hcnt, hcnt_nxt;
    logic                   held, held_nxt;
    logic                   press_ev, release_ev, hold_ev, repeat_ev;

    assign raw    = (BTN_ACTIVE_LOW != 0) ? ~btn : btn;
    assign synced = sync[SYNC_STAGES-1];

    always_comb begin
        state_nxt  = state;
        dbc_nxt    = dbc;
        hcnt_nxt   = hcnt;
        held_nxt   = held;
        press_ev   = 1'b0;
        release_ev = 1'b0;
        hold_ev    = 1'b0;
        repeat_ev  = 1'b0;

        // Hold/repeat timing keeps running through a release bounce; pulses
        // only come out of the state that owns them.
        if (state == ST_PRESSED || state == ST_HELD || state == ST_ARM_RELEASE) begin
            if (!held) begin
                if (hcnt == HOLD_LAST) begin
                    held_nxt = 1'b1;
                    hcnt_nxt = '0;
                    hold_ev  = (state == ST_PRESSED);
                end else if (hcnt != HCNT_MAX) begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end else if (REPEAT_CYCLES > 0) begin
                if (hcnt == REP_LAST) begin
                    hcnt_nxt  = '0;
                    repeat_ev = (state == ST_HELD);
                end else if (hcnt != HCNT_MAX) begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end
        end

        case (state)
            ST_IDLE: begin
                if (synced) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt = ST_PRESSED;
                        press_ev  = 1'b1;
                    end else begin
                        state_nxt = ST_ARM_PRESS;
                        dbc_nxt   = DW'(1);
                    end
                end
            end
            ST_ARM_PRESS: begin
                if (!synced) begin
                    state_nxt = ST_IDLE;
                    dbc_nxt   = '0;
                end else if (dbc == DEB_LAST) begin
                    state_nxt = ST_PRESSED;
                    press_ev  = 1'b1;
                end else begin
                    dbc_nxt = dbc + 1'b1;
                end
            end
            ST_PRESSED, ST_HELD: begin
                if (!synced) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nxt  = ST_IDLE;
                        release_ev = 1'b1;
                    end else begin
                        state_nxt = ST_ARM_RELEASE;
                        dbc_nxt   = DW'(1);
                    end
                end else if (held_nxt) begin
                    state_nxt = ST_HELD;
                end
            end
            ST_ARM_RELEASE: begin
                if (synced) begin
                    state_nxt = held_nxt ? ST_HELD : ST_PRESSED;
                    dbc_nxt   = '0;
                end else if (dbc == DEB_LAST) begin
                    state_nxt  = ST_IDLE;
                    release_ev = 1'b1;
                end else begin
                    dbc_nxt = dbc + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (press_ev) begin
            hcnt_nxt = '0;
            held_nxt = 1'b0;
            dbc_nxt  = '0;
        end
        if (release_ev) begin
            hcnt_nxt  = '0;
            held_nxt  = 1'b0;
            dbc_nxt   = '0;
            hold_ev   = 1'b0;
            repeat_ev = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync          <= '0;
            state         <= ST_IDLE;
            dbc           <= '0;
            hcnt          <= '0;
            held          <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            hold          <= 1'b0;
            repeat_pulse  <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], raw};
            state         <= state_nxt;
            dbc           <= dbc_nxt;
            hcnt          <= hcnt_nxt;
            held          <= held_nxt;
            level         <= (state_nxt != ST_IDLE) && (state_nxt != ST_ARM_PRESS);
            press         <= press_ev & event_en;
            release_pulse <= release_ev & event_en;
            hold          <= hold_ev & event_en;
            repeat_pulse  <= repeat_ev & event_en;
            toggle        <= toggle ^ (press_ev & event_en);
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-channel button event controller: one independent debounce/event
// channel per button input.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int BTN_COUNT       = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HOLD_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 2000000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BTN_COUNT-1:0] btn,
    input  logic [BTN_COUNT-1:0] event_en,
    output logic [BTN_COUNT-1:0] level,
    output logic [BTN_COUNT-1:0] press,
    output logic [BTN_COUNT-1:0] release_pulse,
    output logic [BTN_COUNT-1:0] hold,
    output logic [BTN_COUNT-1:0] repeat_pulse,
    output logic [BTN_COUNT-1:0] toggle
);

    for (genvar i = 0; i < BTN_COUNT; i++) begin : gen_chan
        btn_event_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .btn           (btn[i]),
            .event_en      (event_en[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .hold          (hold[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .toggle        (toggle[i])
        );
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with short debounce/hold/repeat times;
// a second instance covers active-low inputs.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] btn, event_en;
    logic [1:0] level, press, release_pulse, hold, repeat_pulse, toggle;
    logic [1:0] btn_al, en_al;
    logic [1:0] level_al, press_al, release_al, hold_al, repeat_al, toggle_al;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    btn_event_ctrl #(
        .BTN_COUNT(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .BTN_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn(btn), .event_en(event_en),
        .level(level), .press(press), .release_pulse(release_pulse),
        .hold(hold), .repeat_pulse(repeat_pulse), .toggle(toggle)
    );

    btn_event_ctrl #(
        .BTN_COUNT(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .BTN_ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .reset_n(reset_n), .btn(btn_al), .event_en(en_al),
        .level(level_al), .press(press_al), .release_pulse(release_al),
        .hold(hold_al), .repeat_pulse(repeat_al), .toggle(toggle_al)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] b, input logic [1:0] en);
        btn      = b;
        event_en = en;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_al  = 2'b11;
        en_al   = 2'b11;
        applyStimulus(2'b00, 2'b11);
        stepCycles(3);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_press", press, 0);
        checkOutput("rst_release", release_pulse, 0);
        checkOutput("rst_hold", hold, 0);
        checkOutput("rst_repeat", repeat_pulse, 0);
        checkOutput("rst_toggle", toggle, 0);
        reset_n = 1'b1;
        stepCycles(2);

        $display("[TB] press latency, hold and repeat on channel 0");
        applyStimulus(2'b01, 2'b11);
        for (int i = 1; i <= 6; i++) begin
            stepCycles(1);
            checkOutput("press0_lat", press[0], i == 6);
            checkOutput("level0_lat", level[0], i == 6);
        end
        for (int rel = 1; rel <= 30; rel++) begin
            stepCycles(1);
            checkOutput("hold0", hold[0], rel == 10);
            checkOutput("repeat0", repeat_pulse[0], (rel > 10) && ((rel - 10) % 3 == 0));
            if (rel == 1) begin
                checkOutput("press0_once", press[0], 0);
                checkOutput("toggle0", toggle[0], 1);
            end
        end
        applyStimulus(2'b00, 2'b11);
        for (int i = 1; i <= 6; i++) begin
            stepCycles(1);
            checkOutput("release0", release_pulse[0], i == 6);
            checkOutput("level0_fall", level[0], i < 6);
            if (i >= 3)
                checkOutput("repeat0_arm_rel", repeat_pulse[0], 0);
        end
        stepCycles(2);

        $display("[TB] bounce rejection on channel 0");
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus({1'b0, c < 3}, 2'b11);
                stepCycles(1);
                checkOutput("bounce", {level[0], press[0], release_pulse[0]}, 0);
            end
        end
        applyStimulus(2'b00, 2'b11);
        for (int i = 0; i < 6; i++) begin
            stepCycles(1);
            checkOutput("bounce_tail", {level[0], press[0], release_pulse[0]}, 0);
        end

        $display("[TB] masked events on channel 1");
        applyStimulus(2'b10, 2'b01);
        for (int i = 1; i <= 7; i++) begin
            stepCycles(1);
            checkOutput("press1_masked", press[1], 0);
            checkOutput("level1", level[1], i >= 6);
            if (i == 7)
                checkOutput("toggle1_masked", toggle[1], 0);
        end
        applyStimulus(2'b00, 2'b01);
        for (int i = 1; i <= 6; i++) begin
            stepCycles(1);
            checkOutput("release1_masked", release_pulse[1], 0);
            if (i == 6)
                checkOutput("level1_fall", level[1], 0);
        end
        applyStimulus(2'b00, 2'b11);
        stepCycles(2);

        $display("[TB] reset during press on channel 0");
        applyStimulus(2'b01, 2'b11);
        stepCycles(6);
        checkOutput("press0_again", press[0], 1);
        checkOutput("toggle0_flip", toggle[0], 0);
        stepCycles(4);
        reset_n = 1'b0;
        stepCycles(1);
        checkOutput("midrst_level", level, 0);
        checkOutput("midrst_pulses", {press, release_pulse, hold, repeat_pulse}, 0);
        checkOutput("midrst_toggle", toggle, 0);
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            stepCycles(1);
            checkOutput("no_release_rst", release_pulse[0], 0);
            checkOutput("repress0", press[0], i == 6);
            if (i == 6)
                checkOutput("toggle0_after_rst", toggle[0], 1);
        end
        applyStimulus(2'b00, 2'b11);
        stepCycles(8);

        $display("[TB] active-low instance");
        btn_al = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            stepCycles(1);
            checkOutput("al_press", press_al, (i == 6) ? 2'b10 : 2'b00);
            checkOutput("al_level", level_al, (i == 6) ? 2'b10 : 2'b00);
        end

        $display("[TB] simultaneous press on both channels");
        applyStimulus(2'b11, 2'b11);
        for (int i = 1; i <= 6; i++) begin
            stepCycles(1);
            checkOutput("both_press", press, (i == 6) ? 2'b11 : 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
